wb_rr_arbiter_4: RTL and testbench



---
 rtl/wb_rr_arbiter_4_pkg.sv | 28 ++
 rtl/wb_rr_arbiter_4_select.sv | 27 ++
 rtl/wb_rr_arbiter_4.sv | 139 +++++++++++++
 tb/tb_wb_rr_arbiter_4.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_rr_arbiter_4_pkg.sv
// Shared constants for the four-port Wishbone round-robin arbiter:
// grant-vector width, index width, watchdog width and FSM encoding.
package wb_rr_arbiter_4_pkg;

  localparam int GRANT_W = 4;
  localparam int IDX_W   = 2;
  localparam int WD_W    = 16;

  // Reset value of the last-winner pointer: pointing at master 3 makes
  // master 0 the first candidate after reset.
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(GRANT_W - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Binary index of a one-hot vector; an all-zero vector maps to 0.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [GRANT_W-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < GRANT_W; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_4_select.sv
// Combinational rotate-priority encoder: picks the first requester
// scanning last+1, last+2, ... modulo 4.
module wb_rr_select
  import wb_rr_arbiter_4_pkg::*;
(
  input  logic [GRANT_W-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [GRANT_W-1:0] grant,
  output logic               valid
);

  // Scan from the position after the previous winner, wrapping to it last.
  always_comb begin
    logic [IDX_W-1:0] idx;
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 1; i <= GRANT_W; i++) begin
      idx = last + IDX_W'(i);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter_4.sv
// Four-master round-robin Wishbone arbiter sharing one slave port.
// Grants last for a whole bus cycle; a watchdog ends stalled strobes
// with a locally generated error.
module wb_rr_arbiter_4
  import wb_rr_arbiter_4_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 32,
  parameter int          DATA_WIDTH   = 32,
  parameter int          SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [GRANT_W*ADDR_WIDTH-1:0]    wbm_adr_i,
  input  logic [GRANT_W*DATA_WIDTH-1:0]    wbm_dat_i,
  output logic [GRANT_W*DATA_WIDTH-1:0]    wbm_dat_o,
  input  logic [GRANT_W-1:0]               wbm_we_i,
  input  logic [GRANT_W*SELECT_WIDTH-1:0]  wbm_sel_i,
  input  logic [GRANT_W-1:0]               wbm_stb_i,
  input  logic [GRANT_W-1:0]               wbm_cyc_i,
  output logic [GRANT_W-1:0]               wbm_ack_o,
  output logic [GRANT_W-1:0]               wbm_err_o,
  output logic [GRANT_W-1:0]               wbm_rty_o,
  output logic [ADDR_WIDTH-1:0]            wbs_adr_o,
  output logic [DATA_WIDTH-1:0]            wbs_dat_o,
  input  logic [DATA_WIDTH-1:0]            wbs_dat_i,
  output logic [SELECT_WIDTH-1:0]          wbs_sel_o,
  output logic                             wbs_we_o,
  output logic                             wbs_stb_o,
  output logic                             wbs_cyc_o,
  input  logic                             wbs_ack_i,
  input  logic                             wbs_err_i,
  input  logic                             wbs_rty_i,
  output logic [GRANT_W-1:0]               grant_o
);

  localparam logic            WD_EN       = (TIMEOUT != 0);
  localparam logic [WD_W-1:0] TIMEOUT_CNT = WD_W'(TIMEOUT);

  arb_state_e         state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [WD_W-1:0]    wd_q, wd_d;

  logic [GRANT_W-1:0] sel_grant;
  logic               sel_valid;
  logic               busy;
  logic [IDX_W-1:0]   gnt_idx;
  logic               raw_stb;
  logic               slave_term;
  logic               timeout;
  logic [GRANT_W-1:0] route_mask;

  wb_rr_select u_select (
    .req   (wbm_cyc_i),
    .last  (last_q),
    .grant (sel_grant),
    .valid (sel_valid)
  );

  assign busy    = (state_q == ST_BUSY);
  assign gnt_idx = onehot_to_idx(grant_q);
  assign grant_o = grant_q;

  // State, grant, last-winner and watchdog registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= LAST_RESET;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

  // Next-state logic: grant on any cyc in IDLE, release when the owner drops cyc.
  // NOTE: every signal gets its default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          state_d = ST_BUSY;
          grant_d = sel_grant;
          last_d  = onehot_to_idx(sel_grant);
        end
      end
      ST_BUSY: begin
        if ((wbm_cyc_i & grant_q) == '0) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Watchdog: count unanswered strobe cycles, fire when the count hits TIMEOUT.
  always_comb begin
    raw_stb    = busy & wbm_stb_i[gnt_idx];
    slave_term = wbs_ack_i | wbs_err_i | wbs_rty_i;
    timeout    = WD_EN && raw_stb && (wd_q == TIMEOUT_CNT);
    if (WD_EN && raw_stb && !slave_term && !timeout) wd_d = wd_q + 1'b1;
    else                                            wd_d = '0;
  end

  // Slave-side multiplexing from the granted master (master 0 slice when idle).
  always_comb begin
    wbs_adr_o = wbm_adr_i[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    wbs_dat_o = wbm_dat_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    wbs_sel_o = wbm_sel_i[int'(gnt_idx)*SELECT_WIDTH +: SELECT_WIDTH];
    wbs_we_o  = busy & wbm_we_i[gnt_idx];
    wbs_cyc_o = busy & wbm_cyc_i[gnt_idx];
    wbs_stb_o = raw_stb & ~timeout;
  end

  // Termination routing: only the granted master sees slave terminations;
  // a watchdog timeout overrides whatever the slave drives that cycle.
  always_comb begin
    route_mask = busy ? grant_q : '0;
    wbm_ack_o  = route_mask & {GRANT_W{wbs_ack_i & ~timeout}};
    wbm_err_o  = route_mask & {GRANT_W{(wbs_err_i & ~timeout) | timeout}};
    wbm_rty_o  = route_mask & {GRANT_W{wbs_rty_i & ~timeout}};
    wbm_dat_o  = {GRANT_W{wbs_dat_i}};
  end

endmodule

// File: tb/tb_wb_rr_arbiter_4.sv
// Directed self-checking bench for wb_rr_arbiter_4. Two instances share
// all stimulus: dut with TIMEOUT=4 and dut_nowd with the watchdog disabled.
module tb_wb_rr_arbiter_4;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            clk;
  logic            rst;
  logic [4*AW-1:0] m_adr;
  logic [4*DW-1:0] m_dat_w;
  logic [3:0]      m_we, m_stb, m_cyc;
  logic [4*SW-1:0] m_sel;
  logic [DW-1:0]   s_dat_r;
  logic            s_ack, s_err, s_rty;

  logic [4*DW-1:0] m_dat_r, z_dat_r;
  logic [3:0]      m_ack, m_err, m_rty, z_ack, z_err, z_rty;
  logic [AW-1:0]   s_adr, z_adr;
  logic [DW-1:0]   s_dat_w, z_dat_w;
  logic [SW-1:0]   s_sel, z_sel;
  logic            s_we, s_stb, s_cyc, z_we, z_stb, z_cyc;
  logic [3:0]      grant, z_grant;

  int n_checks = 0;
  int n_fail   = 0;

  wb_rr_arbiter_4 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SELECT_WIDTH(SW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat_w), .wbm_dat_o(m_dat_r),
    .wbm_we_i(m_we), .wbm_sel_i(m_sel), .wbm_stb_i(m_stb), .wbm_cyc_i(m_cyc),
    .wbm_ack_o(m_ack), .wbm_err_o(m_err), .wbm_rty_o(m_rty),
    .wbs_adr_o(s_adr), .wbs_dat_o(s_dat_w), .wbs_dat_i(s_dat_r), .wbs_sel_o(s_sel),
    .wbs_we_o(s_we), .wbs_stb_o(s_stb), .wbs_cyc_o(s_cyc),
    .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .grant_o(grant)
  );

  wb_rr_arbiter_4 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SELECT_WIDTH(SW), .TIMEOUT(0)) dut_nowd (
    .clk(clk), .rst(rst),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat_w), .wbm_dat_o(z_dat_r),
    .wbm_we_i(m_we), .wbm_sel_i(m_sel), .wbm_stb_i(m_stb), .wbm_cyc_i(m_cyc),
    .wbm_ack_o(z_ack), .wbm_err_o(z_err), .wbm_rty_o(z_rty),
    .wbs_adr_o(z_adr), .wbs_dat_o(z_dat_w), .wbs_dat_i(s_dat_r), .wbs_sel_o(z_sel),
    .wbs_we_o(z_we), .wbs_stb_o(z_stb), .wbs_cyc_o(z_cyc),
    .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .grant_o(z_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net: the directed sequence is far shorter than this bound.
  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: observed no end of test, required end of test");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One step lands 1 time unit after the rising edge; settle lets inputs propagate.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    m_adr = '0; m_dat_w = '0; m_we = '0; m_stb = '0; m_cyc = '0; m_sel = '0;
    s_dat_r = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    settle();
    check({tag, "_grant"}, grant, 4'b0000);
    check({tag, "_cyc"},   s_cyc, 1'b0);
    check({tag, "_stb"},   s_stb, 1'b0);
    check({tag, "_we"},    s_we,  1'b0);
    check({tag, "_ack"},   m_ack, 4'b0000);
    check({tag, "_err"},   m_err, 4'b0000);
    check({tag, "_rty"},   m_rty, 4'b0000);
  endtask

  logic [3:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] sticky_err;

  initial begin
    rst = 1'b1;
    clear_inputs();

    // ---- 1: single read from master 2 ----
    do_reset("rst1");
    m_cyc = 4'b0100; m_stb = 4'b0100; m_sel = 16'hF00;
    m_adr[2*AW +: AW] = 32'h0000_0100;
    settle();
    check("t1_no_grant_yet", grant, 4'b0000);
    check("t1_cyc_low_yet", s_cyc, 1'b0);
    tick();
    s_ack = 1'b1; s_dat_r = 32'h1234_ABCD;
    settle();
    check("t1_grant", grant, 4'b0100);
    check("t1_wbs_cyc", s_cyc, 1'b1);
    check("t1_wbs_adr", s_adr, 32'h0000_0100);
    check("t1_wbs_we", s_we, 1'b0);
    check("t1_ack_route", m_ack, 4'b0100);
    check("t1_rdata_s2", m_dat_r[2*DW +: DW], 32'h1234_ABCD);
    tick();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    settle();
    check("t1_grant_held", grant, 4'b0100);
    tick();
    s_ack = 1'b1;
    settle();
    check("t1_released", grant, 4'b0000);
    check("t1_idle_ack_ignored", m_ack, 4'b0000);
    check("t1_idle_cyc", s_cyc, 1'b0);
    tick();
    s_ack = 1'b0;

    // ---- 2: all four request continuously, each leaves after one ack ----
    do_reset("rst2");
    m_cyc = 4'hF; m_stb = 4'hF;
    settle();
    check("t2_start_idle", grant, 4'b0000);
    for (int n = 0; n < 5; n++) begin
      tick();
      s_ack = 1'b1;
      settle();
      check($sformatf("t2_grant_%0d", n), grant, exp_order[n]);
      check($sformatf("t2_ack_%0d", n), m_ack, exp_order[n]);
      tick();
      s_ack = 1'b0;
      m_cyc = m_cyc & ~exp_order[n];
      m_stb = m_stb & ~exp_order[n];
      settle();
      check($sformatf("t2_hold_%0d", n), grant, exp_order[n]);
      tick();
      m_cyc = m_cyc | exp_order[n];
      m_stb = m_stb | exp_order[n];
      settle();
      check($sformatf("t2_gap_%0d", n), grant, 4'b0000);
    end

    // ---- 3: locked sequence from master 1, master 0 waiting ----
    do_reset("rst3");
    m_cyc = 4'b0010; m_stb = 4'b0010;
    tick();
    m_cyc = 4'b0011; m_stb = 4'b0011; s_ack = 1'b1;
    settle();
    check("t3_grant_m1", grant, 4'b0010);
    check("t3_ack_m1", m_ack, 4'b0010);
    tick();
    s_ack = 1'b0; m_stb = 4'b0001;
    settle();
    check("t3_locked_a", grant, 4'b0010);
    check("t3_stb_gap", s_stb, 1'b0);
    check("t3_cyc_kept", s_cyc, 1'b1);
    tick();
    m_stb = 4'b0011; s_err = 1'b1;
    settle();
    check("t3_err_m1", m_err, 4'b0010);
    tick();
    s_err = 1'b0; m_stb = 4'b0001;
    settle();
    check("t3_locked_b", grant, 4'b0010);
    tick();
    m_stb = 4'b0011; s_rty = 1'b1;
    settle();
    check("t3_rty_m1", m_rty, 4'b0010);
    tick();
    s_rty = 1'b0; m_cyc = 4'b0001; m_stb = 4'b0001;
    settle();
    check("t3_locked_c", grant, 4'b0010);
    tick();
    settle();
    check("t3_idle", grant, 4'b0000);
    tick();
    settle();
    check("t3_grant_m0", grant, 4'b0001);

    // ---- 4: watchdog with TIMEOUT=4, silent slave on master 3 ----
    do_reset("rst4");
    m_cyc = 4'b1000; m_stb = 4'b1000;
    settle();
    for (int c = 1; c <= 10; c++) begin
      tick();
      s_ack = (c == 10);
      settle();
      if (c == 5 || c == 10) begin
        check($sformatf("t4_err_c%0d", c), m_err, 4'b1000);
        check($sformatf("t4_stb_c%0d", c), s_stb, 1'b0);
      end else begin
        check($sformatf("t4_err_c%0d", c), m_err, 4'b0000);
        check($sformatf("t4_stb_c%0d", c), s_stb, 1'b1);
      end
      check($sformatf("t4_nowd_err_c%0d", c), z_err, 4'b0000);
    end
    check("t4_ack_discarded", m_ack, 4'b0000);
    check("t4_nowd_ack", z_ack, 4'b1000);
    tick();
    s_ack = 1'b0;
    settle();

    // ---- 5: watchdog disabled, slave silent for 1000 cycles ----
    sticky_err = '0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      settle();
      sticky_err = sticky_err | z_err;
    end
    check("t5_no_err", sticky_err, 4'b0000);
    check("t5_stb_still_high", z_stb, 1'b1);

    // ---- 6: asynchronous reset during master 3 transfer ----
    check("t6_pre_grant", grant, 4'b1000);
    rst = 1'b1;
    #1;
    check("t6_cyc_dropped", s_cyc, 1'b0);
    check("t6_stb_dropped", s_stb, 1'b0);
    check("t6_grant_cleared", grant, 4'b0000);
    check("t6_no_err", m_err, 4'b0000);
    tick();
    rst = 1'b0;
    settle();
    check("t6_idle_after_rst", grant, 4'b0000);
    tick();
    settle();
    check("t6_regrant_m3", grant, 4'b1000);
    check("t6_cyc_back", s_cyc, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
